// File: rtl/seq_serializer.sv
// LSB-first parallel-to-serial framer with registered outputs and a one-cycle done pulse.
// Optional frame repetition is compiled in with `define SEQ_SER_LOOP_EN.
module seq_serializer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             stop,
  input  logic             loop,
  output logic             seq,
  output logic             valid,
  output logic             ready,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic             seq_r, seq_s;
  logic             valid_r, valid_s;
  logic             ready_r, ready_s;
  logic             done_r, done_s;

`ifdef SEQ_SER_LOOP_EN
  logic             loop_r, loop_s;
  logic [WIDTH-1:0] word_r, word_s;
`else
  logic             loop_unused_s;
  assign loop_unused_s = loop;
`endif

  // Next-state, datapath and output decode; cnt counts bits already presented on seq.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    seq_s   = 1'b0;
    valid_s = 1'b0;
    ready_s = 1'b1;
    done_s  = 1'b0;
`ifdef SEQ_SER_LOOP_EN
    loop_s  = loop_r;
    word_s  = word_r;
`endif
    case (state_r)
      IDLE: begin
        if (load && !stop) begin
          state_s = SHIFT;
          cnt_s   = CNT_ONE;
          shreg_s = data;
          seq_s   = data[0];
          valid_s = 1'b1;
          ready_s = 1'b0;
`ifdef SEQ_SER_LOOP_EN
          loop_s  = loop;
          word_s  = data;
`endif
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
`ifdef SEQ_SER_LOOP_EN
          loop_s  = 1'b0;
`endif
        end else if (cnt_r == CNT_LAST) begin
`ifdef SEQ_SER_LOOP_EN
          if (loop_r) begin
            // Restart straight from the saved word so the stream has no gap.
            cnt_s   = CNT_ONE;
            shreg_s = word_r;
            seq_s   = word_r[0];
            valid_s = 1'b1;
            ready_s = 1'b0;
          end else begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            done_s  = 1'b1;
          end
`else
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          done_s  = 1'b1;
`endif
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
          seq_s   = shreg_r[1];
          valid_s = 1'b1;
          ready_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      shreg_r <= {WIDTH{1'b0}};
      seq_r   <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
`ifdef SEQ_SER_LOOP_EN
      loop_r  <= 1'b0;
      word_r  <= {WIDTH{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      seq_r   <= seq_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
      done_r  <= done_s;
`ifdef SEQ_SER_LOOP_EN
      loop_r  <= loop_s;
      word_r  <= word_s;
`endif
    end
  end

  assign seq   = seq_r;
  assign valid = valid_r;
  assign ready = ready_r;
  assign done  = done_r;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed scenarios plus random traffic, checked against
// a queue-of-pending-bits reference model.
module tb_seq_serializer;

  localparam int W = 20;
`ifdef SEQ_SER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, load, stop, loop;
  logic [W-1:0] data;
  logic         seq, valid, ready, done;

  int total = 0;
  int bad   = 0;

  // Reference model: bits still to appear on seq, front = bit currently shown.
  bit           q[$];
  bit           m_done;
  bit           m_loop;
  logic [W-1:0] m_word;

  logic [W-1:0] got;
  int           nvalid;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .stop (stop),
    .loop (loop),
    .seq  (seq),
    .valid(valid),
    .ready(ready),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) q.push_back(w[i]);
  endtask

  // One clock: drive inputs, update model at the edge, check outputs 1 time unit later.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                      input logic s, input logic lp);
    bit exp_valid;
    bit exp_seq;
    rst = r; load = l; data = d; stop = s; loop = lp;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_done = 1'b0;
      m_loop = 1'b0;
    end else if (q.size() != 0) begin
      m_done = 1'b0;
      if (s) begin
        q.delete();
        m_loop = 1'b0;
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          if (m_loop) push_word(m_word);
          else m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (l && !s) begin
        push_word(d);
        m_word = d;
        m_loop = LOOP_EN & lp;
      end
    end
    #1;
    exp_valid = (q.size() != 0);
    exp_seq   = exp_valid ? q[0] : 1'b0;
    check("valid", {31'd0, valid}, {31'd0, exp_valid});
    check("seq",   {31'd0, seq},   {31'd0, exp_seq});
    check("ready", {31'd0, ready}, {31'd0, !exp_valid});
    check("done",  {31'd0, done},  {31'd0, m_done});
    if (valid === 1'b1) begin
      got = {seq, got[W-1:1]};
      nvalid++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; stop = 1'b0; loop = 1'b0; data = '0;
    got = '0; nvalid = 0;
    m_done = 1'b0; m_loop = 1'b0; m_word = '0;

    // Reset for two cycles, then quiet idle.
    step(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 20'h5B6B4, 1'b0, 1'b0);
    idle(3);

    // Single frame of 20'h5B6B4.
    nvalid = 0;
    step(1'b0, 1'b1, 20'h5B6B4, 1'b0, 1'b0);
    idle(19);
    check("frame_bits", {12'd0, got}, 32'h5B6B4);
    check("frame_len", nvalid, 32'd20);
    idle(1);
    check("frame_done", {31'd0, done}, 32'd1);
    check("frame_ready", {31'd0, ready}, 32'd1);
    idle(2);

    // Load held high during a frame: first frame intact, second starts after done.
    nvalid = 0;
    step(1'b0, 1'b1, 20'h5B6B4, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    check("b2b_first", {12'd0, got}, 32'h5B6B4);
    step(1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    check("b2b_gap_done", {31'd0, done}, 32'd1);
    nvalid = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0);
    check("b2b_second", {12'd0, got}, 32'hFFFFF);
    check("b2b_len", nvalid, 32'd20);
    idle(2);

    // Stop while bit 7 is on seq.
    step(1'b0, 1'b1, 20'h5B6B4, 1'b0, 1'b0);
    idle(7);
    step(1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
    check("stop_valid", {31'd0, valid}, 32'd0);
    check("stop_done", {31'd0, done}, 32'd0);
    step(1'b0, 1'b1, 20'h00F0F, 1'b0, 1'b0);
    check("stop_reload", {31'd0, valid}, 32'd1);
    idle(22);

    // Reset mid-frame, then a fresh frame of 20'h00001.
    step(1'b0, 1'b1, 20'h5B6B4, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 1'b1, 20'hABCDE, 1'b1, 1'b0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    nvalid = 0;
    step(1'b0, 1'b1, 20'h00001, 1'b0, 1'b0);
    idle(19);
    check("rst_fresh", {12'd0, got}, 32'h00001);
    check("rst_len", nvalid, 32'd20);
    idle(2);

    // Stop and load together in idle: stop wins.
    step(1'b0, 1'b1, 20'h12345, 1'b1, 1'b0);
    check("stop_load_idle", {31'd0, valid}, 32'd0);

`ifdef SEQ_SER_LOOP_EN
    // Looping frame repeats without gaps until stop.
    nvalid = 0;
    step(1'b0, 1'b1, 20'h5B6B4, 1'b0, 1'b1);
    idle(59);
    check("loop_len", nvalid, 32'd60);
    check("loop_bits", {12'd0, got}, 32'h5B6B4);
    step(1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
    check("loop_stop", {31'd0, valid}, 32'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) == 0, ($urandom % 3) == 0, W'($urandom),
           ($urandom % 16) == 0, ($urandom % 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter: WIDTH, 20, number of bits per frame; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 load  input  1  request to capture data; accepted only when ready=1.
REQ-005 data  input  WIDTH  parallel word to serialize; sampled on the accepting edge only.
REQ-006 stop  input  1  abort of the current frame.
REQ-007 loop  input  1  repeat-frame request; sampled on the accepting edge; ignored unless SEQ_SER_LOOP_EN is defined.
REQ-008 seq  output  1  serial bit stream, LSB first; feeds the sequence detector seq input.
REQ-009 valid  output  1  seq carries a frame bit this cycle.
REQ-010 ready  output  1  block idle and able to accept load.
REQ-011 done  output  1  one-cycle pulse after the last bit of a non-looping frame.

Function
REQ-012 All outputs SHALL be registered; no combinational input-to-output path.
REQ-013 The FSM SHALL have two states, IDLE and SHIFT, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 IDLE: ready=1, valid=0, seq=0; done=1 only in the cycle after a frame completes.
REQ-015 IDLE and load=1 and stop=0 at an edge: the block SHALL capture data, drive seq=data[0], set valid=1 and ready=0, and move to SHIFT. Latency is one cycle.
REQ-016 SHIFT: each edge SHALL advance to the next bit (data[1], data[2], ...), so that exactly WIDTH consecutive valid cycles occur.
REQ-017 The edge ending the data[WIDTH-1] cycle SHALL return the block to IDLE with valid=0, seq=0, ready=1, done=1.
REQ-018 load while ready=0 SHALL be ignored; data changes during SHIFT SHALL NOT affect the output.
REQ-019 A load in the done cycle SHALL be accepted, giving exactly one idle cycle between back-to-back frames.
REQ-020 stop=1 in SHIFT SHALL return the block to IDLE on that edge with valid=0, seq=0, ready=1, and done=0.
REQ-021 stop=1 and load=1 together in IDLE: stop wins and load is dropped.
REQ-022 stop=1 in IDLE SHALL have no effect beyond REQ-021.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, seq=0, valid=0, ready=1, done=0, and clear the counter, the shift register and the loop flag.
REQ-024 rst SHALL take priority over load and stop, including mid-frame; a partial frame SHALL NOT resume.
REQ-025 After rst deasserts, load SHALL be accepted on the first edge.

Configuration
REQ-026 Macro SEQ_SER_LOOP_EN defined: a frame accepted with loop=1 SHALL restart from the captured word with no gap after bit WIDTH-1. In this case valid stays 1, done stays 0 and ready stays 0 until stop or rst.
REQ-027 SEQ_SER_LOOP_EN undefined: the loop input SHALL be unused, no loop flag or word copy is synthesized, and behaviour follows REQ-015..REQ-022 only.

Verification
REQ-028 rst=1 for 2 cycles, then idle: seq=0, valid=0, ready=1, done=0 throughout.
REQ-029 load=1 with data=20'h5B6B4 for one cycle -> seq over 20 valid cycles = 0,0,1,0,1,1,0,1,0,1,1,0,1,1,0,1,1,0,1,0; then done=1 for one cycle and ready=1.
REQ-030 Second load held high during a frame with data=20'hFFFFF -> the first frame is unaltered; the second frame starts in the cycle after done and emits 20 ones.
REQ-031 stop=1 at bit 7 of a 20'h5B6B4 frame -> next cycle valid=0, seq=0, ready=1, done=0; a following load is accepted immediately.
REQ-032 rst=1 at bit 10 of a frame -> next cycle all outputs are at reset values; a fresh load of 20'h00001 emits 1 followed by 19 zeros.
REQ-033 With SEQ_SER_LOOP_EN, load=1 and loop=1 with data=20'h5B6B4 -> 60 consecutive valid cycles repeating the REQ-029 pattern with done=0; stop then gives IDLE on the next edge.
